branch_table_ctrl: RTL and testbench
====================================

BRANCH_TABLE_CTRL -- requirements
Module: branch_table_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, update queue depth in entries (power of 2, >=2).
REQ-002 SHALL have parameter MAXWAIT, default 3, number of cycles a queued update may be deferred by lookups before it is forced.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port resolve_valid  input  1  resolved branch offered by execute stage.
REQ-006 SHALL have ports resolve_addr  input  32  branch PC, and resolve_dest  input  32  branch target.
REQ-007 SHALL have port resolve_taken  input  1  resolved direction.
REQ-008 SHALL have port resolve_ready  output  1  queue accepts the resolved branch this cycle.
REQ-009 SHALL have port lookup_valid  input  1  fetch stage requests the shared table port.
REQ-010 SHALL have port lookup_stall  output  1  fetch lookup denied this cycle.
REQ-011 SHALL have port flush_req  input  1  request full table invalidation.
REQ-012 SHALL have ports upd_valid  output  1, upd_index  output  4, upd_addr  output  32, upd_dest  output  32, upd_taken  output  1: table write command.
REQ-013 SHALL have ports inv_valid  output  1 and inv_index  output  4: table invalidate command.
REQ-014 SHALL have ports q_count  output  $clog2(QDEPTH)+1  queue occupancy, and busy  output  1  high while in SWEEP.

Function
REQ-015 SHALL buffer resolved branches in a QDEPTH-entry FIFO of {addr, dest, taken}; enqueue when resolve_valid && resolve_ready.
REQ-016 SHALL drive resolve_ready = !full && state==IDLE && !flush_req (combinational).
REQ-017 SHALL compute upd_index = (sum of the eight 4-bit nibbles of head addr) mod 16.
REQ-018 SHALL implement FSM states IDLE and SWEEP only.
REQ-019 In IDLE, SHALL grant the table port to the head update (upd_valid=1, combinational from head) when queue non-empty and any of: !lookup_valid, queue full, wait_cnt==MAXWAIT.
REQ-020 SHALL pop the head on the rising edge ending a cycle with upd_valid=1; simultaneous push and pop SHALL keep q_count unchanged.
REQ-021 SHALL drive lookup_stall = lookup_valid && (upd_valid || state==SWEEP).
REQ-022 SHALL keep wait_cnt (2 bits min): increment when queue non-empty and upd_valid=0; clear on grant or empty queue; saturate at MAXWAIT.
REQ-023 IDLE with flush_req=1 SHALL move to SWEEP next edge, clear FIFO and wait_cnt, load sweep counter 0; upd_valid SHALL be 0 that cycle.
REQ-024 In SWEEP SHALL assert inv_valid=1, busy=1, inv_index=sweep counter; counter increments each cycle; after inv_index 15 is issued, return to IDLE.
REQ-025 flush_req during SWEEP SHALL restart the counter at 0 on the next edge.
REQ-026 SWEEP SHALL last exactly 16 cycles absent further flush_req; upd_valid=0 and resolve_ready=0 throughout.
REQ-027 Outputs upd_addr/upd_dest/upd_taken/upd_index are don't-care when upd_valid=0; inv_index don't-care when inv_valid=0.

Reset
REQ-028 rst=1 at a rising edge SHALL set state IDLE, FIFO empty (q_count=0), wait_cnt=0, sweep counter=0, overriding any other input including flush_req.
REQ-029 After reset SHALL present upd_valid=0, inv_valid=0, busy=0, lookup_stall=lookup_valid&&0, resolve_ready=!flush_req.
REQ-030 Reset during SWEEP SHALL abort the sweep immediately (no further inv_valid).

Verification
REQ-031 Push addr=0x0000_0124, dest=0x200, taken=1 with lookup_valid=0 -> next cycle upd_valid=1, upd_index=7, q_count 1->0.
REQ-032 Hold lookup_valid=1, push 1 entry -> upd_valid=0 for 3 cycles, forced grant in 4th cycle with lookup_stall=1.
REQ-033 Fill 4 entries with lookup_valid=1 -> resolve_ready=0, upd_valid=1, lookup_stall=1 each cycle until not full.
REQ-034 flush_req with 2 queued -> q_count=0, inv_index 0..15 over 16 cycles, busy=1, then IDLE; flush_req again at inv_index=9 -> restarts at 0.
REQ-035 rst mid-SWEEP at inv_index=5 -> next cycle inv_valid=0, busy=0, q_count=0, resolve_ready=1.

Source files
------------

// File: rtl/branch_table_ctrl.sv
// Branch table update controller.
// Resolved branches are queued in a small FIFO and written into the branch
// table through a single port that is shared with fetch-stage lookups. A
// queued update yields to lookups for at most MAXWAIT cycles, and is forced
// through earlier when the queue is full. A flush request walks all 16 table
// entries and invalidates each one (SWEEP state).
module branch_table_ctrl #(
    parameter int QDEPTH  = 4,
    parameter int MAXWAIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      resolve_valid,
    input  logic [31:0]               resolve_addr,
    input  logic [31:0]               resolve_dest,
    input  logic                      resolve_taken,
    output logic                      resolve_ready,
    input  logic                      lookup_valid,
    output logic                      lookup_stall,
    input  logic                      flush_req,
    output logic                      upd_valid,
    output logic [3:0]                upd_index,
    output logic [31:0]               upd_addr,
    output logic [31:0]               upd_dest,
    output logic                      upd_taken,
    output logic                      inv_valid,
    output logic [3:0]                inv_index,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int WRAW = $clog2(MAXWAIT + 1);
    localparam int WW   = (WRAW < 2) ? 2 : WRAW;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sweep_q, sweep_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_q, wait_d;

    logic [31:0]     addr_mem  [QDEPTH];
    logic [31:0]     dest_mem  [QDEPTH];
    logic            taken_mem [QDEPTH];

    logic            empty;
    logic            full;
    logic            push;
    logic            flush_clr;

    // Table index hash: sum of the eight address nibbles, wrapping mod 16.
    function automatic logic [3:0] nibble_sum(input logic [31:0] a);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + a[4*i +: 4];
        end
        return s;
    endfunction

    // Deferral counter increment that sticks at MAXWAIT.
    function automatic logic [WW-1:0] wait_sat(input logic [WW-1:0] w);
        return (w == WW'(MAXWAIT)) ? w : w + WW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(QDEPTH));
    assign push      = resolve_valid && resolve_ready;
    assign flush_clr = (state_q == IDLE) && flush_req;

    assign upd_addr  = addr_mem[rd_ptr_q];
    assign upd_dest  = dest_mem[rd_ptr_q];
    assign upd_taken = taken_mem[rd_ptr_q];
    assign upd_index = nibble_sum(upd_addr);
    assign inv_index = sweep_q;
    assign q_count   = count_q;

    // State register and all control state; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sweep_q  <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    // FIFO payload storage; pointers alone define validity, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= resolve_addr;
            dest_mem[wr_ptr_q]  <= resolve_dest;
            taken_mem[wr_ptr_q] <= resolve_taken;
        end
    end

    // Next-state logic: IDLE <-> SWEEP and the sweep counter.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    sweep_d = 4'd0;
                end
            end
            SWEEP: begin
                if (flush_req) begin
                    sweep_d = 4'd0;
                end else if (sweep_q == 4'd15) begin
                    state_d = IDLE;
                    sweep_d = 4'd0;
                end else begin
                    sweep_d = sweep_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sweep_d = 4'd0;
            end
        endcase
    end

    // Queue pointers, occupancy and lookup-deferral counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;
        if (flush_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wait_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (upd_valid) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, upd_valid})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (empty || upd_valid) wait_d = '0;
            else                    wait_d = wait_sat(wait_q);
        end
    end

    // Output decode: table-port arbitration and sweep indication.
    always_comb begin
        resolve_ready = 1'b0;
        upd_valid     = 1'b0;
        inv_valid     = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                resolve_ready = !full && !flush_req;
                upd_valid     = !flush_req && !empty &&
                                (!lookup_valid || full || (wait_q == WW'(MAXWAIT)));
            end
            SWEEP: begin
                inv_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
        lookup_stall = lookup_valid && (upd_valid || (state_q == SWEEP));
    end

endmodule

// File: tb/tb_branch_table_ctrl.sv
// Bench for branch_table_ctrl: directed vector table, hand-written sweep and
// reset sequences, then random traffic against a queue-based reference model.
module tb_branch_table_ctrl;

    localparam int QD = 4;
    localparam int MW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_valid;
    logic [31:0] resolve_addr;
    logic [31:0] resolve_dest;
    logic        resolve_taken;
    logic        resolve_ready;
    logic        lookup_valid;
    logic        lookup_stall;
    logic        flush_req;
    logic        upd_valid;
    logic [3:0]  upd_index;
    logic [31:0] upd_addr;
    logic [31:0] upd_dest;
    logic        upd_taken;
    logic        inv_valid;
    logic [3:0]  inv_index;
    logic [2:0]  q_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    branch_table_ctrl #(.QDEPTH(QD), .MAXWAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .resolve_valid(resolve_valid), .resolve_addr(resolve_addr),
        .resolve_dest(resolve_dest), .resolve_taken(resolve_taken),
        .resolve_ready(resolve_ready),
        .lookup_valid(lookup_valid), .lookup_stall(lookup_stall),
        .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_addr(upd_addr),
        .upd_dest(upd_dest), .upd_taken(upd_taken),
        .inv_valid(inv_valid), .inv_index(inv_index),
        .q_count(q_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] addr; logic [31:0] dest; logic taken; } ent_t;
    ent_t mq[$];
    int   m_wait  = 0;
    bit   m_sweep = 0;
    int   m_sidx  = 0;
    bit   g_m, p_m, e_m;

    function automatic logic [3:0] ref_idx(input logic [31:0] a);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'((a >> (4*i)) & 32'hF);
        return 4'(s % 16);
    endfunction

    function automatic bit e_ready();
        return !m_sweep && (mq.size() < QD) && !flush_req;
    endfunction

    function automatic bit e_uv();
        return !m_sweep && !flush_req && (mq.size() > 0) &&
               (!lookup_valid || (mq.size() == QD) || (m_wait == MW));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); m_wait = 0; m_sweep = 0; m_sidx = 0;
        end else if (m_sweep) begin
            if (flush_req) m_sidx = 0;
            else if (m_sidx == 15) begin m_sweep = 0; m_sidx = 0; end
            else m_sidx = m_sidx + 1;
        end else if (flush_req) begin
            mq.delete(); m_wait = 0; m_sweep = 1; m_sidx = 0;
        end else begin
            g_m = e_uv();
            p_m = resolve_valid && e_ready();
            e_m = (mq.size() == 0);
            if (g_m) begin void'(mq.pop_front()); m_wait = 0; end
            else if (e_m) m_wait = 0;
            else if (m_wait < MW) m_wait = m_wait + 1;
            if (p_m) mq.push_back('{resolve_addr, resolve_dest, resolve_taken});
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit rv, input logic [31:0] a,
                         input logic [31:0] d, input bit tk, input bit lv, input bit fl);
        rst = r; resolve_valid = rv; resolve_addr = a; resolve_dest = d;
        resolve_taken = tk; lookup_valid = lv; flush_req = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model();
        bit uv;
        uv = e_uv();
        chk("m_upd_valid", 32'(upd_valid), 32'(uv));
        chk("m_resolve_ready", 32'(resolve_ready), 32'(e_ready()));
        chk("m_lookup_stall", 32'(lookup_stall), 32'(lookup_valid && (uv || m_sweep)));
        chk("m_inv_valid", 32'(inv_valid), 32'(m_sweep));
        chk("m_busy", 32'(busy), 32'(m_sweep));
        chk("m_q_count", 32'(q_count), 32'(mq.size()));
        if (uv) begin
            chk("m_upd_index", 32'(upd_index), 32'(ref_idx(mq[0].addr)));
            chk("m_upd_addr", upd_addr, mq[0].addr);
            chk("m_upd_dest", upd_dest, mq[0].dest);
            chk("m_upd_taken", 32'(upd_taken), 32'(mq[0].taken));
        end
        if (m_sweep) chk("m_inv_index", 32'(inv_index), 32'(m_sidx));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rv; logic [31:0] addr; bit lv; bit fl;
        bit uv; int idx; bit rdy; bit st; int qc; bit inv; int iidx; bit bz;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(bit rv, logic [31:0] a, bit lv, bit fl, bit uv, int idx,
                                 bit rdy, bit st, int qc, bit inv, int iidx, bit bz);
        vec_t v;
        v.rv = rv; v.addr = a; v.lv = lv; v.fl = fl; v.uv = uv; v.idx = idx;
        v.rdy = rdy; v.st = st; v.qc = qc; v.inv = inv; v.iidx = iidx; v.bz = bz;
        return v;
    endfunction

    task automatic sweep_check(input int idx, input string nm);
        chk({nm, "_inv_valid"}, 32'(inv_valid), 32'd1);
        chk({nm, "_inv_index"}, 32'(inv_index), 32'(idx));
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        chk({nm, "_ready"}, 32'(resolve_ready), 32'd0);
        chk({nm, "_upd_valid"}, 32'(upd_valid), 32'd0);
    endtask

    task automatic idle_check(input string nm);
        chk({nm, "_inv_valid"}, 32'(inv_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_q_count"}, 32'(q_count), 32'd0);
        chk({nm, "_ready"}, 32'(resolve_ready), 32'd1);
    endtask

    initial begin
        //          rv  addr          lv fl  uv idx rdy st qc inv iidx bz
        vecs.push_back(mkv(0, 32'h0,         0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // reset state
        vecs.push_back(mkv(1, 32'h0000_0124, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // push
        vecs.push_back(mkv(0, 32'h0,         0, 0, 1, 7, 1, 0, 1, 0, 0, 0)); // grant idx 7
        vecs.push_back(mkv(0, 32'h0,         0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h1111_1111, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // push under lookup
        vecs.push_back(mkv(0, 32'h0,         1, 0, 0, 0, 1, 0, 1, 0, 0, 0)); // deferred 1
        vecs.push_back(mkv(0, 32'h0,         1, 0, 0, 0, 1, 0, 1, 0, 0, 0)); // deferred 2
        vecs.push_back(mkv(0, 32'h0,         1, 0, 0, 0, 1, 0, 1, 0, 0, 0)); // deferred 3
        vecs.push_back(mkv(0, 32'h0,         1, 0, 1, 8, 1, 1, 1, 0, 0, 0)); // forced grant
        vecs.push_back(mkv(0, 32'h0,         0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h0000_0001, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // fill A
        vecs.push_back(mkv(1, 32'h0000_0022, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0)); // fill B
        vecs.push_back(mkv(1, 32'h0000_0303, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0)); // fill C
        vecs.push_back(mkv(1, 32'h0000_4004, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0)); // fill D
        vecs.push_back(mkv(1, 32'hFFFF_FFFF, 1, 0, 1, 1, 0, 1, 4, 0, 0, 0)); // full: forced
        vecs.push_back(mkv(0, 32'h0,         1, 0, 0, 0, 1, 0, 3, 0, 0, 0));
        vecs.push_back(mkv(0, 32'h0,         0, 0, 1, 4, 1, 0, 3, 0, 0, 0)); // grant B
        vecs.push_back(mkv(0, 32'h0,         0, 1, 0, 0, 0, 0, 2, 0, 0, 0)); // flush, 2 queued
        vecs.push_back(mkv(0, 32'h0,         1, 0, 0, 0, 0, 1, 0, 1, 0, 1)); // sweep idx 0

        drive(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();

        foreach (vecs[k]) begin
            drive(0, vecs[k].rv, vecs[k].addr, vecs[k].addr ^ 32'h5A5A, vecs[k].addr[0],
                  vecs[k].lv, vecs[k].fl);
            @(negedge clk);
            chk($sformatf("v%0d_upd_valid", k), 32'(upd_valid), 32'(vecs[k].uv));
            if (vecs[k].uv) chk($sformatf("v%0d_upd_index", k), 32'(upd_index), 32'(vecs[k].idx));
            chk($sformatf("v%0d_ready", k), 32'(resolve_ready), 32'(vecs[k].rdy));
            chk($sformatf("v%0d_stall", k), 32'(lookup_stall), 32'(vecs[k].st));
            chk($sformatf("v%0d_q_count", k), 32'(q_count), 32'(vecs[k].qc));
            chk($sformatf("v%0d_inv_valid", k), 32'(inv_valid), 32'(vecs[k].inv));
            if (vecs[k].inv) chk($sformatf("v%0d_inv_index", k), 32'(inv_index), 32'(vecs[k].iidx));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].bz));
            next_cycle();
        end

        // Remainder of the first sweep, then back to IDLE.
        for (int i = 1; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            sweep_check(i, "sw1");
            next_cycle();
        end
        @(negedge clk);
        idle_check("sw1_end");
        next_cycle();

        // Flush again; re-flush at index 9 restarts the walk.
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("fl2_upd_valid", 32'(upd_valid), 32'd0);
        chk("fl2_ready", 32'(resolve_ready), 32'd0);
        next_cycle();
        for (int i = 0; i <= 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, (i == 9));
            @(negedge clk);
            sweep_check(i, "sw2a");
            next_cycle();
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            sweep_check(i, "sw2b");
            next_cycle();
        end
        @(negedge clk);
        idle_check("sw2_end");
        next_cycle();

        // Reset in the middle of a sweep aborts it.
        drive(0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        for (int i = 0; i <= 5; i++) begin
            drive((i == 5), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            sweep_check(i, "sw3");
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle_check("rst_abort");
        next_cycle();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            drive(($urandom % 60) == 0, ($urandom % 10) < 6, $urandom, $urandom,
                  1'($urandom), ($urandom % 10) < 5, ($urandom % 40) == 0);
            @(negedge clk);
            chk_model();
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
